// File: rtl/ip1_argmax_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ip1_argmax_pkg
//  Brief    : Shared constants and state encoding for the argmax classifier
//  Revision : 1.0 - initial release
// ============================================================================
package ip1_argmax_pkg;

    localparam int LANES           = 4;
    localparam int DW              = 16;
    localparam int NUM_CLASS       = 64;
    localparam int IDX_W           = 6;
    localparam int BEATS_PER_FRAME = NUM_CLASS / LANES;

    // ACCUM takes beats; HOLD waits for the result handshake
    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

endpackage : ip1_argmax_pkg
`default_nettype wire

// File: rtl/ip1_argmax_lane_reduce.sv
`default_nettype none
// ============================================================================
//  Module   : argmax_lane_reduce
//  Brief    : Combinational signed max over the lanes of one beat; returns
//             the max score and its lane, lowest lane winning on ties
//  Revision : 1.0 - initial release
// ============================================================================
module argmax_lane_reduce #(
    parameter int LANES  = 4,
    parameter int DW     = 16,
    parameter int LANE_W = 2
) (
    input  logic [LANES*DW-1:0] scores,
    output logic [DW-1:0]       max_score,
    output logic [LANE_W-1:0]   max_lane
);

    // Compare chain from lane 0 upward; strict greater keeps the lower lane on ties
    always_comb begin
        max_score = scores[0 +: DW];
        max_lane  = '0;
        for (int k = 1; k < LANES; k++) begin
            if ($signed(scores[k*DW +: DW]) > $signed(max_score)) begin
                max_score = scores[k*DW +: DW];
                max_lane  = LANE_W'(k);
            end
        end
    end

endmodule : argmax_lane_reduce
`default_nettype wire

// File: rtl/ip1_argmax.sv
`default_nettype none
// ============================================================================
//  Module   : ip1_argmax
//  Brief    : Streaming argmax over a frame of signed class scores. Stage 1
//             reduces each beat to its best lane, stage 2 keeps the running
//             best and publishes the winner two cycles after the eop beat.
//  Revision : 1.0 - initial release
// ============================================================================
module ip1_argmax #(
    parameter int LANES     = ip1_argmax_pkg::LANES,
    parameter int DW        = ip1_argmax_pkg::DW,
    parameter int NUM_CLASS = ip1_argmax_pkg::NUM_CLASS,
    parameter int IDX_W     = ip1_argmax_pkg::IDX_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [LANES*DW-1:0] blob_din,
    input  logic                blob_din_en,
    input  logic                blob_din_eop,
    output logic                blob_din_rdy,
    output logic [IDX_W-1:0]    result_class,
    output logic [DW-1:0]       result_score,
    output logic                result_err,
    output logic                result_en,
    input  logic                result_rdy
);

    import ip1_argmax_pkg::*;

    localparam int c_beats  = NUM_CLASS / LANES;
    localparam int c_beat_w = (c_beats > 1) ? $clog2(c_beats) : 1;
    localparam int c_lane_w = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [c_beat_w-1:0] c_last_beat = c_beat_w'(c_beats - 1);

    // Control
    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_rdy;
    logic                w_accept;

    // Beat counting
    logic [c_beat_w-1:0] r_beat_cnt;
    logic                r_overrun;
    logic                w_frame_err;

    // Lane reduction of the incoming beat
    logic [DW-1:0]       w_lane_max;
    logic [c_lane_w-1:0] w_lane;
    logic [IDX_W-1:0]    w_class;

    // Stage 1
    logic                r_s1_valid;
    logic [DW-1:0]       r_s1_max;
    logic [IDX_W-1:0]    r_s1_class;
    logic                r_s1_first;
    logic                r_s1_eop;
    logic                r_s1_err;

    // Stage 2
    logic [DW-1:0]       r_best_score;
    logic [IDX_W-1:0]    r_best_class;
    logic                w_take;
    logic [DW-1:0]       w_final_score;
    logic [IDX_W-1:0]    w_final_class;

    // Result
    logic                r_result_en;
    logic [IDX_W-1:0]    r_result_class;
    logic [DW-1:0]       r_result_score;
    logic                r_result_err;

    assign w_accept = blob_din_en & r_rdy;

    // Error if eop lands anywhere but the last beat, or the frame already overran
    assign w_frame_err = r_overrun | (r_beat_cnt != c_last_beat);

    // Class index wraps modulo NUM_CLASS once a frame overruns
    assign w_class = IDX_W'((int'(r_beat_cnt) * LANES + int'(w_lane)) % NUM_CLASS);

    argmax_lane_reduce #(
        .LANES  (LANES),
        .DW     (DW),
        .LANE_W (c_lane_w)
    ) u_lane_reduce (
        .scores    (blob_din),
        .max_score (w_lane_max),
        .max_lane  (w_lane)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ACCUM;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state: leave ACCUM on accepted eop, leave HOLD on result handshake
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ACCUM: begin
                if (w_accept && blob_din_eop) begin
                    w_state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (r_result_en && result_rdy) begin
                    w_state_nxt = ACCUM;
                end
            end
            default: w_state_nxt = ACCUM;
        endcase
    end

    // Ready is registered so it reads 0 while reset is held and 1 right after
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rdy <= 1'b0;
        end else begin
            r_rdy <= (w_state_nxt == ACCUM);
        end
    end

    // Beat counter with sticky overrun flag; both clear on the eop beat
    always_ff @(posedge clk) begin
        if (rst) begin
            r_beat_cnt <= '0;
            r_overrun  <= 1'b0;
        end else if (w_accept) begin
            if (blob_din_eop) begin
                r_beat_cnt <= '0;
                r_overrun  <= 1'b0;
            end else if (r_beat_cnt == c_last_beat) begin
                r_beat_cnt <= '0;
                r_overrun  <= 1'b1;
            end else begin
                r_beat_cnt <= r_beat_cnt + 1'b1;
            end
        end
    end

    // Stage 1: capture the beat's best lane, its class index and frame flags
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_max   <= '0;
            r_s1_class <= '0;
            r_s1_first <= 1'b0;
            r_s1_eop   <= 1'b0;
            r_s1_err   <= 1'b0;
        end else begin
            r_s1_valid <= w_accept;
            if (w_accept) begin
                r_s1_max   <= w_lane_max;
                r_s1_class <= w_class;
                r_s1_first <= (r_beat_cnt == '0) && !r_overrun;
                r_s1_eop   <= blob_din_eop;
                r_s1_err   <= w_frame_err;
            end
        end
    end

    // Strictly greater replaces the best, so earlier classes win ties
    assign w_take        = r_s1_first || ($signed(r_s1_max) > $signed(r_best_score));
    assign w_final_score = w_take ? r_s1_max   : r_best_score;
    assign w_final_class = w_take ? r_s1_class : r_best_class;

    // Stage 2: running best across the frame
    always_ff @(posedge clk) begin
        if (rst) begin
            r_best_score <= '0;
            r_best_class <= '0;
        end else if (r_s1_valid && w_take) begin
            r_best_score <= r_s1_max;
            r_best_class <= r_s1_class;
        end
    end

    // Result registers load only when result_en rises and hold until handshake
    always_ff @(posedge clk) begin
        if (rst) begin
            r_result_en    <= 1'b0;
            r_result_class <= '0;
            r_result_score <= '0;
            r_result_err   <= 1'b0;
        end else if (r_s1_valid && r_s1_eop) begin
            r_result_en    <= 1'b1;
            r_result_class <= w_final_class;
            r_result_score <= w_final_score;
            r_result_err   <= r_s1_err;
        end else if (r_result_en && result_rdy) begin
            r_result_en    <= 1'b0;
        end
    end

    assign blob_din_rdy = r_rdy;
    assign result_en    = r_result_en;
    assign result_class = r_result_class;
    assign result_score = r_result_score;
    assign result_err   = r_result_err;

endmodule : ip1_argmax
`default_nettype wire

// File: tb/tb_ip1_argmax.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ip1_argmax
//  Brief    : Directed self-checking bench for ip1_argmax
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ip1_argmax;

    localparam int LANES     = 4;
    localparam int DW        = 16;
    localparam int NUM_CLASS = 64;
    localparam int IDX_W     = 6;

    logic                clk = 1'b0;
    logic                rst;
    logic [LANES*DW-1:0] blob_din;
    logic                blob_din_en;
    logic                blob_din_eop;
    logic                blob_din_rdy;
    logic [IDX_W-1:0]    result_class;
    logic [DW-1:0]       result_score;
    logic                result_err;
    logic                result_en;
    logic                result_rdy;

    logic [DW-1:0]       sc [0:127];

    int n_cmp = 0;
    int n_bad = 0;

    ip1_argmax #(
        .LANES     (LANES),
        .DW        (DW),
        .NUM_CLASS (NUM_CLASS),
        .IDX_W     (IDX_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .blob_din     (blob_din),
        .blob_din_en  (blob_din_en),
        .blob_din_eop (blob_din_eop),
        .blob_din_rdy (blob_din_rdy),
        .result_class (result_class),
        .result_score (result_score),
        .result_err   (result_err),
        .result_en    (result_en),
        .result_rdy   (result_rdy)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic fill(input logic [DW-1:0] v);
        for (int i = 0; i < 128; i++) sc[i] = v;
    endtask

    task automatic send_frame(input int nbeats);
        for (int b = 0; b < nbeats; b++) begin
            for (int k = 0; k < LANES; k++) blob_din[k*DW +: DW] = sc[b*LANES + k];
            blob_din_en  = 1'b1;
            blob_din_eop = (b == nbeats - 1);
            tick;
        end
        blob_din_en  = 1'b0;
        blob_din_eop = 1'b0;
    endtask

    // Bounded wait for result_en; cycle 1 is the cycle right after the eop edge
    task automatic wait_result(input string tag);
        int lat;
        lat = 1;
        while (result_en !== 1'b1 && lat < 8) begin
            tick;
            lat++;
        end
        check_val({tag, "_lat"}, lat, 2);
    endtask

    task automatic frame_check(input string tag, input int nbeats,
                               input logic [31:0] ecls, input logic [31:0] escore,
                               input logic [31:0] eerr);
        send_frame(nbeats);
        wait_result(tag);
        check_val({tag, "_class"}, result_class, ecls);
        check_val({tag, "_score"}, result_score, escore);
        check_val({tag, "_err"},   result_err,   eerr);
        if (result_rdy) begin
            tick;
            check_val({tag, "_en_drop"}, result_en, 0);
            check_val({tag, "_rdy_back"}, blob_din_rdy, 1);
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic seen;
        rst          = 1'b1;
        blob_din     = '0;
        blob_din_en  = 1'b0;
        blob_din_eop = 1'b0;
        result_rdy   = 1'b1;
        tick; tick; tick;
        check_val("rst_rdy",   blob_din_rdy, 0);
        check_val("rst_en",    result_en,    0);
        check_val("rst_class", result_class, 0);
        check_val("rst_score", result_score, 0);
        check_val("rst_err",   result_err,   0);
        rst = 1'b0;
        tick;
        check_val("rdy_after_rst", blob_din_rdy, 1);

        // Ramp: score equals class index
        for (int i = 0; i < 128; i++) sc[i] = 16'(i);
        frame_check("ramp", 16, 63, 63, 0);

        // Tie between classes 17 and 42 keeps 17
        fill(16'hFFFB);
        sc[17] = 16'd100;
        sc[42] = 16'd100;
        frame_check("tie", 16, 17, 100, 0);

        // All negative: -300 everywhere, class 5 = -2
        fill(16'hFED4);
        sc[5] = 16'hFFFE;
        frame_check("neg", 16, 5, 32'h0000FFFE, 0);

        // Short frame: eop on beat 9
        for (int i = 0; i < 128; i++) sc[i] = 16'(i);
        frame_check("short", 10, 39, 39, 1);

        // 20 beats then eop; class 70 wraps to 6
        fill(16'd10);
        sc[70] = 16'd50;
        frame_check("long", 21, 6, 50, 1);

        // Good frame clears the error
        for (int i = 0; i < 128; i++) sc[i] = 16'(i);
        frame_check("good", 16, 63, 63, 0);

        // Single-beat frame, lanes 1 and 2 tie
        fill(16'd0);
        sc[0] = 16'd3; sc[1] = 16'd9; sc[2] = 16'd9; sc[3] = 16'hFFFF;
        frame_check("single", 1, 1, 9, 1);

        // Backpressure: result held, beats offered during HOLD ignored
        result_rdy = 1'b0;
        fill(16'd1);
        sc[20] = 16'd33;
        send_frame(16);
        wait_result("hold");
        for (int i = 0; i < 10; i++) begin
            blob_din     = {LANES{16'h7FFF}};
            blob_din_en  = 1'b1;
            blob_din_eop = (i % 2 == 1);
            tick;
            check_val("hold_en",    result_en,    1);
            check_val("hold_class", result_class, 20);
            check_val("hold_score", result_score, 33);
            check_val("hold_rdy",   blob_din_rdy, 0);
        end
        blob_din_en  = 1'b0;
        blob_din_eop = 1'b0;
        result_rdy   = 1'b1;
        tick;
        check_val("release_en",  result_en,    0);
        check_val("release_rdy", blob_din_rdy, 1);
        fill(16'd0);
        sc[3] = 16'd77;
        frame_check("post_hold", 16, 3, 77, 0);

        // Reset in the middle of a frame
        for (int b = 0; b < 7; b++) begin
            blob_din     = {LANES{16'd500}};
            blob_din_en  = 1'b1;
            blob_din_eop = 1'b0;
            tick;
        end
        rst = 1'b1;
        tick;
        check_val("midrst_rdy",   blob_din_rdy, 0);
        check_val("midrst_en",    result_en,    0);
        check_val("midrst_score", result_score, 0);
        tick;
        rst          = 1'b0;
        blob_din_en  = 1'b0;
        tick;
        check_val("midrst_rdy_back", blob_din_rdy, 1);
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            seen = seen | result_en;
            tick;
        end
        check_val("no_stale", seen, 0);
        fill(16'hFFFF);
        sc[3] = 16'd1234;
        frame_check("post_rst", 16, 3, 1234, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_ip1_argmax
`default_nettype wire

// File: doc/ip1_argmax.md
IP1_ARGMAX -- requirements
Module: ip1_argmax

Interface
REQ-001 Parameter LANES, default 4, 16-bit scores per input beat.
REQ-002 Parameter DW, default 16, score width in bits, signed two's complement.
REQ-003 Parameter NUM_CLASS, default 64, classes per frame; NUM_CLASS/LANES = 16 beats per frame.
REQ-004 Parameter IDX_W, default 6, equal to clog2(NUM_CLASS).
REQ-005 The block SHALL have one clock; reset is synchronous and active-high. Ports are named clk and rst.
REQ-006 clk  input  1  rising-edge clock for all state.
REQ-007 rst  input  1  synchronous, active-high reset.
REQ-008 blob_din  input  LANES*DW  score beat; lane k at bits [k*DW+:DW]; lane 0 is the lowest class of the beat.
REQ-009 blob_din_en  input  1  beat valid.
REQ-010 blob_din_eop  input  1  last beat of the frame; qualified by blob_din_en.
REQ-011 blob_din_rdy  output  1  block can accept a beat.
REQ-012 result_class  output  IDX_W  winning class index.
REQ-013 result_score  output  DW  winning score.
REQ-014 result_err  output  1  frame beat count was not NUM_CLASS/LANES.
REQ-015 result_en  output  1  result valid.
REQ-016 result_rdy  input  1  downstream accepts the result.

Function
REQ-017 A beat SHALL be accepted only when blob_din_en=1 and blob_din_rdy=1; blob_din_en while blob_din_rdy=0 SHALL be ignored.
REQ-018 The state machine SHALL have states ACCUM and HOLD.
- ACCUM: blob_din_rdy=1.
- ACCUM to HOLD when the eop beat is accepted.
- HOLD: blob_din_rdy=0 until the result handshake completes.
REQ-019 Stage 1 SHALL register, per accepted beat: the lane maximum, its lane number (lowest lane on ties), the beat index and the eop flag.
REQ-020 Stage 2 SHALL keep a running best. Update when the first beat of a frame arrives, or when the stage-1 max is strictly greater than the best (signed compare). Ties SHALL keep the earlier (lower) class.
REQ-021 Class index SHALL be beat_index*LANES + lane, truncated to IDX_W bits.
REQ-022 The beat counter SHALL count accepted beats per frame and clear after eop.
REQ-023 result_err SHALL be set if eop is accepted at a count other than 16, or if more than 16 beats arrive without eop. Beats beyond 16 SHALL still be compared, with the index wrapping modulo NUM_CLASS.
REQ-024 result_en SHALL rise exactly 2 cycles after the eop beat is accepted. It SHALL be held, with result_class/score/err stable, until result_rdy=1.
REQ-025 The result handshake completes in the cycle where result_en=1 and result_rdy=1. In the next cycle result_en=0, the state is ACCUM and blob_din_rdy=1.
REQ-026 A frame of a single beat (eop on beat 0) SHALL yield the best lane of that beat with result_err=1.
REQ-027 Result outputs SHALL change only on the cycle result_en rises.

Reset
REQ-028 On rst=1 at a clock edge, all outputs SHALL be 0: blob_din_rdy, result_en, result_class, result_score, result_err.
REQ-029 Reset SHALL put the state in ACCUM and clear the beat counter, both pipeline stages and the running best.
REQ-030 blob_din_rdy SHALL be 1 in the first cycle after rst deasserts.
REQ-031 Reset mid-frame or during HOLD SHALL discard the partial frame or pending result with no output.

Structure
REQ-032 Package ip1_argmax_pkg SHALL hold LANES, DW, NUM_CLASS, IDX_W, BEATS_PER_FRAME (=16) and the state enum {ACCUM, HOLD}.
REQ-033 Sub-module argmax_lane_reduce SHALL be a combinational signed compare tree: LANES scores in, max and lane index out, lowest lane on ties. Stage 1 instantiates it once.

Verification
REQ-034 Scores 0..63 = class index, 16 beats with eop on beat 15, result_rdy=1 -> result_class=63, score=63, err=0; result_en exactly 2 cycles after eop.
REQ-035 All scores -5 except classes 17 and 42 = 100 -> class 17 (tie keeps lowest), score 100.
REQ-036 All scores -300 except class 5 = -2 -> class 5, score -2 (0xFFFE), which checks the signed compare.
REQ-037 Eop on beat 9 -> result_err=1. Then 20 beats then eop -> err=1. A following good frame -> err=0.
REQ-038 result_rdy held low 10 cycles after result_en -> outputs stable, blob_din_rdy=0, beats offered while rdy=0 are ignored. Release result_rdy -> blob_din_rdy=1 the next cycle.
REQ-039 rst asserted at beat 7 of a frame, then a full frame with max at class 3 -> class 3 and no stale result.
